dcache_direct: RTL and testbench
================================

Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipelined cpu's data port (d_readM/d_writeM/d_address/d_data) and data memory.
- Produces the cacheStall signal the cpu consumes; the cpu freezes its pipeline while cacheStall=1.
- Line = 4 words of 16 bits. Memory transfers whole lines on read and single words on write.

Parameters:
- WORD_SIZE, 16, data/address width.
- INDEX_BITS, 2, line-index width; number of lines = 2**INDEX_BITS.

Ports:
- Clk  input  1  clock, rising edge.
- Reset_N  input  1  synchronous active-low reset.
- c_readM  input  1  cpu read request, level, held while cacheStall=1.
- c_writeM  input  1  cpu write request, level, held while cacheStall=1.
- c_address  input  16  cpu word address. offset=[1:0], index=[INDEX_BITS+1:2], tag=rest.
- c_wdata  input  16  cpu write data.
- c_rdata  output  16  read data, valid when c_readM=1 and cacheStall=0.
- cacheStall  output  1  cpu must hold request and freeze.
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  1=word write, 0=line read.
- mem_addr  output  16  line read: {tag,index,2'b00}; write: c_address.
- mem_wdata  output  16  write word.
- mem_rdata  input  64  line data, word0 in [15:0]; valid in the mem_ack cycle.
- mem_ack  input  1  one-cycle completion pulse.

Behaviour:
- Storage per line: valid bit, tag, 4 data words. hit = valid[index] && tag match.
- Reset (Reset_N=0 at posedge):
  - all valid cleared; state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Outputs during reset: c_rdata=0, cacheStall=0.
  - Reset mid-FILL/WRITE abandons the transfer; a late mem_ack is ignored.
- States: IDLE, FILL, WRITE, WDONE.
- IDLE:
  - cacheStall = (c_readM && !hit) || c_writeM, combinational.
  - Read hit: c_rdata = word[offset] in the same cycle (0-cycle latency), stall=0.
  - Read miss: next state FILL.
  - Write (hit or miss): next state WRITE.
  - c_readM and c_writeM both high: write wins, read ignored.
- FILL:
  - mem_req=1, mem_we=0, mem_addr line-aligned; cacheStall=1.
  - On mem_ack: store mem_rdata, set tag, set valid, go to IDLE.
  - The next cycle hits and stall drops, so read-miss latency = memory latency + 1 cycle.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=c_address, mem_wdata=c_wdata; cacheStall=1.
  - On mem_ack: if hit, update the cached word (valid/tag unchanged); go to WDONE.
  - Write miss never allocates.
- WDONE:
  - cacheStall=0 for exactly one cycle so the cpu retires the store; no memory request; next state IDLE.
- mem_req drops in the cycle after mem_ack.
- No request active: state stays IDLE, mem_req=0.
- All index and tag arithmetic is pure bit slicing; no wrap beyond address width.
- Invariant: at most one outstanding memory transaction.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, adds outputs hit_count (16) and miss_count (16), both reset to 0.
  - hit_count increments on an IDLE read hit that did not immediately follow a FILL, tracked with a just_filled flag.
  - miss_count increments on each IDLE→FILL transition.
  - Both saturate at 16'hFFFF. Writes are not counted.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then read 0x0010 with memory latency 3 and line {0x4444,0x3333,0x2222,0x1111}:
  - mem_addr=0x0010, mem_req for 3 cycles, cacheStall=1 for 4 cycles, then c_rdata=0x1111.
  - Read 0x0013 next: c_rdata=0x4444, cacheStall=0, no mem_req.
- Conflict: after the above, read 0x0050 (same index, tag differs): miss, refill. Read 0x0010 again: miss again.
- Write hit: write 0xBEEF to 0x0011 (line cached):
  - mem_we=1, mem_addr=0x0011, mem_wdata=0xBEEF.
  - cacheStall falls in the WDONE cycle.
  - Subsequent read 0x0011 hits with 0xBEEF.
- Write miss: write 0x1234 to 0x0100 (not cached): memory written. Subsequent read 0x0100 misses (no allocate).
- Reset mid-operation:
  - Assert Reset_N=0 during FILL: mem_req=0 next cycle, state IDLE.
  - A stray mem_ack is ignored.
  - Read of the previously filled 0x0013 misses.
- DCACHE_STATS_EN: sequence of miss, hit, hit, write, miss → miss_count=2, hit_count=2.

Source files
------------

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-through, no-write-allocate data cache
// that sits between the cpu data port and data memory.
//
// Ports:
//   Clk, Reset_N        clock (rising edge), synchronous active-low reset
//   c_readM, c_writeM   cpu read / write requests (level, held while stalled)
//   c_address           cpu word address: offset [1:0], index above it, tag = rest
//   c_wdata             cpu store data
//   c_rdata             load data (combinational, valid on a read hit in IDLE)
//   cacheStall          combinational freeze request to the cpu
//   mem_req, mem_we     memory request (held until mem_ack); 1 = word write, 0 = line read
//   mem_addr, mem_wdata memory address (line-aligned for reads) and write word
//   mem_rdata, mem_ack  returned line (word0 in [15:0]) and one-cycle completion pulse
//
// Optional build macro DCACHE_STATS_EN adds saturating hit_count / miss_count outputs.

module dcache_direct #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned INDEX_BITS = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_N,
  input  logic                   c_readM,
  input  logic                   c_writeM,
  input  logic [WORD_SIZE-1:0]   c_address,
  input  logic [WORD_SIZE-1:0]   c_wdata,
  output logic [WORD_SIZE-1:0]   c_rdata,
  output logic                   cacheStall,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  input  logic                   mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
`endif
);

  localparam int unsigned OFF_W = 2;
  localparam int unsigned WORDS = 4;
  localparam int unsigned LINES = 2 ** INDEX_BITS;
  localparam int unsigned TAG_W = WORD_SIZE - INDEX_BITS - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_WDONE
  } state_e;

  state_e state_q, state_d;

  // Cache storage: per-line valid bit, tag and four data words.
  logic [LINES-1:0]                    valid_q, valid_d;
  logic [TAG_W-1:0]                    tag_q  [LINES];
  logic [TAG_W-1:0]                    tag_d  [LINES];
  logic [WORDS-1:0][WORD_SIZE-1:0]     data_q [LINES];
  logic [WORDS-1:0][WORD_SIZE-1:0]     data_d [LINES];

  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;

  // Address fields of the live cpu request.
  logic [OFF_W-1:0]      c_off;
  logic [INDEX_BITS-1:0] c_idx;
  logic [TAG_W-1:0]      c_tag;
  logic                  c_hit;

  // Address fields of the outstanding memory transaction (captured at issue).
  logic [OFF_W-1:0]      m_off;
  logic [INDEX_BITS-1:0] m_idx;
  logic [TAG_W-1:0]      m_tag;
  logic                  m_hit;

  logic stall_c;
  logic read_hit_c;

  assign c_off = c_address[OFF_W-1:0];
  assign c_idx = c_address[OFF_W +: INDEX_BITS];
  assign c_tag = c_address[WORD_SIZE-1 -: TAG_W];
  assign c_hit = valid_q[c_idx] && (tag_q[c_idx] == c_tag);

  assign m_off = mem_addr_q[OFF_W-1:0];
  assign m_idx = mem_addr_q[OFF_W +: INDEX_BITS];
  assign m_tag = mem_addr_q[WORD_SIZE-1 -: TAG_W];
  assign m_hit = valid_q[m_idx] && (tag_q[m_idx] == m_tag);

  // Next-state, storage update and memory-request logic.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall_c     = 1'b0;
    read_hit_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A write takes priority over a simultaneous read.
        if (c_writeM) begin
          stall_c     = 1'b1;
          state_d     = S_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = c_address;
          mem_wdata_d = c_wdata;
        end else if (c_readM) begin
          if (c_hit) begin
            read_hit_c = 1'b1;
          end else begin
            stall_c    = 1'b1;
            state_d    = S_FILL;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {c_address[WORD_SIZE-1:OFF_W], OFF_W'(0)};
          end
        end
      end

      S_FILL: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          mem_req_d      = 1'b0;
          data_d[m_idx]  = mem_rdata;
          tag_d[m_idx]   = m_tag;
          valid_d[m_idx] = 1'b1;
          state_d        = S_IDLE;
        end
      end

      S_WRITE: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          // Write-through: refresh the cached copy only if the line is present.
          if (m_hit) begin
            data_d[m_idx][m_off] = mem_wdata_q;
          end
          state_d = S_WDONE;
        end
      end

      S_WDONE: begin
        // One unstalled cycle lets the cpu retire the store.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and memory interface registers.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data arrays need no reset; the valid bits qualify them.
  always_ff @(posedge Clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cacheStall = Reset_N && stall_c;
  assign c_rdata    = (Reset_N && read_hit_c) ? data_q[c_idx][c_off] : '0;

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;
  logic        just_filled_q, just_filled_d;

  // The hit that completes a miss is not counted as a hit.
  always_comb begin
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    just_filled_d = (state_q == S_FILL) && mem_ack;
    if (read_hit_c && !just_filled_q && (hit_count_q != 16'hFFFF)) begin
      hit_count_d = hit_count_q + 16'd1;
    end
    if ((state_q == S_IDLE) && (state_d == S_FILL) && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      just_filled_q <= 1'b0;
    end else begin
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
      just_filled_q <= just_filled_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench for dcache_direct: a driver issues cpu requests and pushes
// expected responses from a reference model (a whole-memory image plus a tag
// directory); a monitor pops and compares whenever the cpu or memory side
// completes. A behavioural memory answers requests with a programmable latency.

module tb_dcache_direct;

  typedef struct {
    bit          wr;
    logic [15:0] rdata;
    int          stall;
  } cpu_exp_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
  } mem_exp_t;

  logic        Clk;
  logic        Reset_N;
  logic        c_readM;
  logic        c_writeM;
  logic [15:0] c_address;
  logic [15:0] c_wdata;
  logic [15:0] c_rdata;
  logic        cacheStall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  dcache_direct dut (
    .Clk        (Clk),
    .Reset_N    (Reset_N),
    .c_readM    (c_readM),
    .c_writeM   (c_writeM),
    .c_address  (c_address),
    .c_wdata    (c_wdata),
    .c_rdata    (c_rdata),
    .cacheStall (cacheStall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  cpu_exp_t    cq[$];
  mem_exp_t    mq[$];
  logic [15:0] bmem    [65536];
  logic [15:0] ref_mem [65536];
  bit          ref_valid [4];
  logic [11:0] ref_tag   [4];
  int          exp_hits;
  int          exp_misses;
  int          lat_cfg;
  int          stray_cnt;
  bit          mon_en;
  bit          done;
  int          errors;
  int          checks;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural memory: acks after lat_cfg request cycles, plus stray acks on demand.
  initial begin
    int cnt;
    int stray_seen;
    cnt = 0;
    stray_seen = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge Clk);
      mem_ack = 1'b0;
      if (!Reset_N) begin
        cnt = 0;
      end else if (stray_seen != stray_cnt) begin
        stray_seen = stray_cnt;
        mem_ack = 1'b1;
        mem_rdata = {$urandom, $urandom};
      end else if (mem_req) begin
        cnt++;
        if (cnt >= lat_cfg) begin
          mem_ack = 1'b1;
          cnt = 0;
          if (mem_we) begin
            bmem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = {bmem[{mem_addr[15:2], 2'd3}], bmem[{mem_addr[15:2], 2'd2}],
                         bmem[{mem_addr[15:2], 2'd1}], bmem[{mem_addr[15:2], 2'd0}]};
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: reset outputs, memory transactions and cpu completions.
  initial begin
    int       stall_cnt;
    int       req_cycles;
    bit       req_prev;
    bit       rst_prev;
    mem_exp_t cur_m;
    cpu_exp_t cur_c;
    stall_cnt = 0;
    req_cycles = 0;
    req_prev = 1'b0;
    rst_prev = 1'b0;
    cur_m = '{we: 1'b0, addr: 16'h0, wdata: 16'h0, lat: -1};
    forever begin
      @(negedge Clk);
      if (!Reset_N) begin
        chk("rst_cacheStall", 32'(cacheStall), 32'd0);
        chk("rst_c_rdata", 32'(c_rdata), 32'd0);
        if (rst_prev) begin
          chk("rst_mem_req", 32'(mem_req), 32'd0);
          chk("rst_mem_we", 32'(mem_we), 32'd0);
          chk("rst_mem_addr", 32'(mem_addr), 32'd0);
          chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        end
        stall_cnt = 0;
        req_cycles = 0;
        req_prev = 1'b0;
        rst_prev = 1'b1;
      end else begin
        rst_prev = 1'b0;
        if (mon_en) begin
          if (mem_req) begin
            if (!req_prev) begin
              chk("mem_req_expected", 32'(mq.size() != 0), 32'd1);
              if (mq.size() != 0) begin
                cur_m = mq.pop_front();
                chk("mem_we", 32'(mem_we), 32'(cur_m.we));
                chk("mem_addr", 32'(mem_addr), 32'(cur_m.addr));
                if (cur_m.we) chk("mem_wdata", 32'(mem_wdata), 32'(cur_m.wdata));
              end else begin
                cur_m.lat = -1;
              end
            end
            req_cycles++;
          end else if (req_prev) begin
            chk("mem_req_cycles", 32'(req_cycles), 32'(cur_m.lat));
            req_cycles = 0;
          end
          req_prev = mem_req;

          if (c_readM || c_writeM) begin
            if (cacheStall) begin
              stall_cnt++;
            end else begin
              chk("cpu_completion_expected", 32'(cq.size() != 0), 32'd1);
              if (cq.size() != 0) begin
                cur_c = cq.pop_front();
                if (!cur_c.wr) chk("c_rdata", 32'(c_rdata), 32'(cur_c.rdata));
                chk("stall_cycles", 32'(stall_cnt), 32'(cur_c.stall));
              end
              stall_cnt = 0;
            end
          end
        end
      end
      if (done) begin
        chk("cpu_queue_drained", 32'(cq.size()), 32'd0);
        chk("mem_queue_drained", 32'(mq.size()), 32'd0);
`ifdef DCACHE_STATS_EN
        chk("hit_count", 32'(hit_count), 32'(exp_hits));
        chk("miss_count", 32'(miss_count), 32'(exp_misses));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // Issue one cpu request, record what the reference model expects, wait for completion.
  task automatic do_op(input bit wr, input bit rd_too, input logic [15:0] addr,
                       input logic [15:0] wd, input int lat);
    logic [1:0]  idx;
    logic [11:0] tg;
    bit          hit;
    int          n;
    idx = addr[3:2];
    tg  = addr[15:4];
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    if (wr) begin
      mq.push_back('{we: 1'b1, addr: addr, wdata: wd, lat: lat});
      cq.push_back('{wr: 1'b1, rdata: 16'h0, stall: lat + 1});
      ref_mem[addr] = wd;
    end else if (hit) begin
      cq.push_back('{wr: 1'b0, rdata: ref_mem[addr], stall: 0});
      exp_hits++;
    end else begin
      mq.push_back('{we: 1'b0, addr: {addr[15:2], 2'b00}, wdata: 16'h0, lat: lat});
      cq.push_back('{wr: 1'b0, rdata: ref_mem[addr], stall: lat + 1});
      ref_valid[idx] = 1'b1;
      ref_tag[idx] = tg;
      exp_misses++;
    end
    lat_cfg   = lat;
    c_address = addr;
    c_wdata   = wd;
    c_writeM  = wr;
    c_readM   = !wr || rd_too;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (n > 40) begin
        $display("FAIL op_timeout: addr 0x%0h still stalled after %0d cycles", addr, n);
        $fatal(1, "timeout");
      end
    end while (cacheStall);
    @(posedge Clk);
    #1;
    c_readM  = 1'b0;
    c_writeM = 1'b0;
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;
    done = 1'b0;
    mon_en = 1'b1;
    stray_cnt = 0;
    lat_cfg = 1;
    Reset_N = 1'b0;
    c_readM = 1'b0;
    c_writeM = 1'b0;
    c_address = '0;
    c_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      bmem[i] = 16'($urandom);
      ref_mem[i] = bmem[i];
    end
    bmem[16'h0010] = 16'h1111; bmem[16'h0011] = 16'h2222;
    bmem[16'h0012] = 16'h3333; bmem[16'h0013] = 16'h4444;
    for (int i = 16'h0010; i <= 16'h0013; i++) ref_mem[i] = bmem[i];
    clear_model();
    idle(3);
    Reset_N = 1'b1;
    idle(2);

    // Fill, hit, conflict refill, write hit/miss without allocation.
    do_op(1'b0, 1'b0, 16'h0010, 16'h0, 3);
    do_op(1'b0, 1'b0, 16'h0013, 16'h0, 3);
    do_op(1'b0, 1'b0, 16'h0050, 16'h0, 2);
    do_op(1'b0, 1'b0, 16'h0010, 16'h0, 2);
    do_op(1'b1, 1'b0, 16'h0011, 16'hBEEF, 2);
    do_op(1'b0, 1'b0, 16'h0011, 16'h0, 2);
    do_op(1'b1, 1'b0, 16'h0100, 16'h1234, 1);
    do_op(1'b0, 1'b0, 16'h0100, 16'h0, 2);
    idle(2);

    // Reset in the middle of a fill, then a stray ack while idle.
    mon_en = 1'b0;
    lat_cfg = 8;
    c_address = 16'h0050;
    c_readM = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (n > 10) begin
        $display("FAIL fill_start_timeout: mem_req never rose");
        $fatal(1, "timeout");
      end
    end while (!mem_req);
    @(posedge Clk);
    #1;
    Reset_N = 1'b0;
    c_readM = 1'b0;
    idle(2);
    Reset_N = 1'b1;
    clear_model();
    mon_en = 1'b1;
    stray_cnt++;
    idle(4);
    do_op(1'b0, 1'b0, 16'h0013, 16'h0, 3);

    // Miss, hit, hit, write, miss.
    do_op(1'b0, 1'b0, 16'h0024, 16'h0, 2);
    do_op(1'b0, 1'b0, 16'h0025, 16'h0, 1);
    do_op(1'b0, 1'b0, 16'h0026, 16'h0, 1);
    do_op(1'b1, 1'b0, 16'h0027, 16'h5A5A, 2);
    do_op(1'b0, 1'b0, 16'h0028, 16'h0, 4);
    idle(1);

    // Randomised traffic over a small address window to force conflicts.
    for (int k = 0; k < 300; k++) begin
      bit          wr;
      bit          rd_too;
      logic [15:0] addr;
      wr     = ($urandom_range(0, 9) < 3);
      rd_too = wr && ($urandom_range(0, 3) == 0);
      addr   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
      do_op(wr, rd_too, addr, 16'($urandom), int'($urandom_range(1, 4)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    done = 1'b1;
  end

endmodule
